// File: rtl/bin8_bcd3_seq_pkg.sv
// rtl/bin8_bcd3_seq_pkg.sv - shared types and constants for the sequential binary-to-BCD converter
package bcd_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int BCD_DIGIT_W    = 4;
    localparam int BCD_ADJ_THRESH = 5;
    localparam int BCD_ADJ_ADD    = 3;

endpackage

// File: rtl/bin8_bcd3_seq_if.sv
// rtl/bin8_bcd3_seq_if.sv - request/result bundle between controller and converter
interface bin8_bcd3_seq_if #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
);
    logic [WIDTH-1:0]    BIN;
    logic                START;
    logic                BUSY;
    logic                DONE;
    logic [4*DIGITS-1:0] BCD;

    modport master (output BIN, output START, input BUSY, input DONE, input BCD);
    modport slave  (input BIN, input START, output BUSY, output DONE, output BCD);
endinterface

// File: rtl/bin8_bcd3_seq_adj.sv
// rtl/bin8_bcd3_seq_adj.sv - combinational add-3-if-at-least-5 stage for one BCD digit
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] d,
    output logic [BCD_DIGIT_W-1:0] q
);
    // Wraps in 4 bits; a legal digit never exceeds 9, so 9+3=12 fits.
    assign q = (d >= BCD_DIGIT_W'(BCD_ADJ_THRESH)) ? d + BCD_DIGIT_W'(BCD_ADJ_ADD) : d;
endmodule

// File: rtl/bin8_bcd3_seq.sv
// rtl/bin8_bcd3_seq.sv - iterative double-dabble converter, one shift per clock; BIN8_BCD3_SEQ_AUTO_EN adds re-convert on input change
module bin8_bcd3_seq
    import bcd_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic CLK,
    input  logic RSTn,
    bin8_bcd3_seq_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int BW = BCD_DIGIT_W * DIGITS;

    state_t            state, state_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic [WIDTH-1:0]  bin_sr, bin_n;
    logic [BW-1:0]     bcd_sr, bcd_sr_n, bcd_adj;
    logic [BW-1:0]     bcd_q, bcd_n;
    logic              busy_q, done_q, done_n;
    logic [BW+WIDTH-1:0] shifted;
    logic              start_int;

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_adj
            bcd_digit_adj u_adj (
                .d(bcd_sr[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
                .q(bcd_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
            );
        end
    endgenerate

`ifdef BIN8_BCD3_SEQ_AUTO_EN
    logic [WIDTH-1:0] last_bin, last_n;
    assign start_int = bus.START | (bus.BIN != last_bin);
`else
    assign start_int = bus.START;
`endif

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        bin_n    = bin_sr;
        bcd_sr_n = bcd_sr;
        bcd_n    = bcd_q;
        done_n   = 1'b0;
`ifdef BIN8_BCD3_SEQ_AUTO_EN
        last_n   = last_bin;
`endif
        // MSB of the binary register falls into bit 0 of the adjusted BCD scratch.
        shifted  = {bcd_adj, bin_sr} << 1;
        case (state)
            IDLE: begin
                if (start_int) begin
                    bin_n    = bus.BIN;
                    bcd_sr_n = '0;
                    cnt_n    = CW'(WIDTH);
                    state_n  = SHIFT;
`ifdef BIN8_BCD3_SEQ_AUTO_EN
                    last_n   = bus.BIN;
`endif
                end
            end
            SHIFT: begin
                bin_n    = shifted[WIDTH-1:0];
                bcd_sr_n = shifted[BW+WIDTH-1:WIDTH];
                cnt_n    = cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    bcd_n   = shifted[BW+WIDTH-1:WIDTH];
                    done_n  = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state    <= IDLE;
            cnt      <= '0;
            bin_sr   <= '0;
            bcd_sr   <= '0;
            bcd_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef BIN8_BCD3_SEQ_AUTO_EN
            last_bin <= '0;
`endif
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            bin_sr   <= bin_n;
            bcd_sr   <= bcd_sr_n;
            bcd_q    <= bcd_n;
            busy_q   <= (state_n == SHIFT);
            done_q   <= done_n;
`ifdef BIN8_BCD3_SEQ_AUTO_EN
            last_bin <= last_n;
`endif
        end
    end

    assign bus.BUSY = busy_q;
    assign bus.DONE = done_q;
    assign bus.BCD  = bcd_q;
endmodule
